// File: rtl/cpu7_ifu_fbuf_if.sv
// Fetch-buffer bus: fill beats from the fetch unit, head entry towards decode.
// master = fetch/decode side, slave = the buffer itself.
interface cpu7_ifu_fbuf_if #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FC_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    logic                   fill_valid;
    logic [31:0]            fill_pc;
    logic [FC_W-1:0]        fill_count;
    logic [32*FETCH_W-1:0]  fill_data;
    logic                   fill_ex;
    logic [5:0]             fill_exccode;
    logic                   fbuf_can_fill;
    logic                   flush;
    logic                   fbuf_dec_valid;
    logic [31:0]            fbuf_dec_inst;
    logic [31:0]            fbuf_dec_pc;
    logic                   fbuf_dec_ex;
    logic [5:0]             fbuf_dec_exccode;
    logic                   dec_fbuf_ready;
    logic [CNT_W-1:0]       fbuf_cnt;
    logic                   fbuf_ovf;

    modport master (
        output fill_valid, fill_pc, fill_count, fill_data, fill_ex, fill_exccode,
        output flush, dec_fbuf_ready,
        input  fbuf_can_fill, fbuf_dec_valid, fbuf_dec_inst, fbuf_dec_pc,
        input  fbuf_dec_ex, fbuf_dec_exccode, fbuf_cnt, fbuf_ovf
    );

    modport slave (
        input  fill_valid, fill_pc, fill_count, fill_data, fill_ex, fill_exccode,
        input  flush, dec_fbuf_ready,
        output fbuf_can_fill, fbuf_dec_valid, fbuf_dec_inst, fbuf_dec_pc,
        output fbuf_dec_ex, fbuf_dec_exccode, fbuf_cnt, fbuf_ovf
    );
endinterface

// File: rtl/cpu7_ifu_fbuf.sv
// Instruction fetch buffer: circular queue between fetch fill beats and decode.
// Optional macro CPU7_IFU_FBUF_BYPASS_EN adds an empty-buffer fill-to-decode bypass.
module cpu7_ifu_fbuf #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 4
) (
    input logic             clock,
    input logic             resetn,
    cpu7_ifu_fbuf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    ptr_t        cnt;
    ptr_t        free_cnt;
    ptr_t        n_wr;
    ptr_t        n_store;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        ex_mem   [DEPTH];
    logic [5:0]  code_mem [DEPTH];

    logic        empty;
    logic        can_fill;
    logic        accept;
    logic        drop;
    logic        pop;
    logic        byp_active;
    logic        byp_take;
    logic        dec_valid;
    logic        ovf;

    logic [31:0] head_inst;
    logic [31:0] head_pc;
    logic        head_ex;
    logic [5:0]  head_code;
    logic [31:0] last_inst;
    logic [31:0] last_pc;
    logic        last_ex;
    logic [5:0]  last_code;
    logic        unused_bits;

    assign rd_idx   = rd_ptr[AW-1:0];
    assign wr_idx   = wr_ptr[AW-1:0];
    assign cnt      = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign free_cnt = PW'(DEPTH) - cnt;

    // Credit comes from the registered occupancy only, never from a same-cycle drain
    assign can_fill = (free_cnt >= PW'(FETCH_W));
    assign accept   = bus.fill_valid & can_fill & ~bus.flush;
    assign drop     = bus.fill_valid & ~can_fill & ~bus.flush;
    assign pop      = ~empty & bus.dec_fbuf_ready & ~bus.flush;

`ifdef CPU7_IFU_FBUF_BYPASS_EN
    assign byp_active = empty & accept & resetn;
`else
    assign byp_active = 1'b0;
`endif
    assign byp_take = byp_active & bus.dec_fbuf_ready;

    // Exception beats always occupy exactly one slot
    always_comb begin
        n_wr = PW'(1);
        if (!bus.fill_ex && FETCH_W > 1) begin
            n_wr = PW'(bus.fill_count) + PW'(1);
        end
        n_store = n_wr - PW'(byp_take);
    end

    always_comb begin
        head_inst = inst_mem[rd_idx];
        head_pc   = pc_mem[rd_idx];
        head_ex   = ex_mem[rd_idx];
        head_code = code_mem[rd_idx];
        if (byp_active) begin
            head_inst = bus.fill_ex ? 32'h0 : bus.fill_data[31:0];
            head_pc   = {bus.fill_pc[31:2], 2'b00};
            head_ex   = bus.fill_ex;
            head_code = bus.fill_ex ? bus.fill_exccode : 6'h0;
        end
    end

    assign dec_valid = (~empty | byp_active) & ~bus.flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + n_store;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    // Shadow of the most recent presented head so outputs stay defined while empty
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_inst <= '0;
            last_pc   <= '0;
            last_ex   <= 1'b0;
            last_code <= '0;
        end else if (dec_valid) begin
            last_inst <= head_inst;
            last_pc   <= head_pc;
            last_ex   <= head_ex;
            last_code <= head_code;
        end
    end

    // A bypassed-and-consumed slot 0 is skipped; remaining slots pack from wr_ptr
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (PW'(j) >= PW'(byp_take) && PW'(j) < n_wr) begin
                    inst_mem[wr_idx + AW'(j) - AW'(byp_take)] <=
                        bus.fill_ex ? 32'h0 : bus.fill_data[32*j +: 32];
                    pc_mem[wr_idx + AW'(j) - AW'(byp_take)] <=
                        {bus.fill_pc[31:2] + 30'(j), 2'b00};
                    ex_mem[wr_idx + AW'(j) - AW'(byp_take)] <= bus.fill_ex;
                    code_mem[wr_idx + AW'(j) - AW'(byp_take)] <=
                        bus.fill_ex ? bus.fill_exccode : 6'h0;
                end
            end
        end
    end

    assign bus.fbuf_can_fill    = can_fill;
    assign bus.fbuf_cnt         = cnt;
    assign bus.fbuf_ovf         = ovf;
    assign bus.fbuf_dec_valid   = dec_valid;
    assign bus.fbuf_dec_inst    = dec_valid ? head_inst : last_inst;
    assign bus.fbuf_dec_pc      = dec_valid ? head_pc   : last_pc;
    assign bus.fbuf_dec_ex      = dec_valid ? head_ex   : last_ex;
    assign bus.fbuf_dec_exccode = dec_valid ? head_code : last_code;

    assign unused_bits = ^bus.fill_pc[1:0];
endmodule
